// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// mem_ctrl_pkg : shared defaults and bank read-pipeline entry for mem_arb_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

  localparam int DEF_N_CLIENTS  = 16;
  localparam int DEF_N_BANKS    = 16;
  localparam int DEF_ADDR_W     = 19;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_STARVE_MAX = 8;

  // Fixed-width client id so the struct is parameter independent (<=256 clients).
  localparam int CID_W = 8;

  typedef struct packed {
    logic             valid;
    logic [CID_W-1:0] cid;
  } pipe_entry_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : N-way round-robin arbiter with a single override index
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  input  logic                 ovr_valid_i,
  input  logic [$clog2(N)-1:0] ovr_idx_i,
  output logic [N-1:0]         gnt_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    if (ovr_valid_i && req_i[ovr_idx_i]) begin
      gnt_o[ovr_idx_i] = 1'b1;
    end else begin
      // First requester at or after the pointer, wrapping modulo N.
      for (int i = 0; i < N; i++) begin
        idx = (int'(ptr_i) + i) % N;
        if (!found && req_i[idx]) begin
          gnt_o[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arb_ctrl.sv
// ============================================================================
// mem_arb_ctrl : multi-client to banked-SRAM arbiter with read return routing
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arb_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int N_CLIENTS  = DEF_N_CLIENTS,
  parameter int N_BANKS    = DEF_N_BANKS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [N_CLIENTS-1:0]                            req_valid_i,
  input  logic [N_CLIENTS-1:0]                            req_write_i,
  input  logic [N_CLIENTS-1:0][ADDR_W-1:0]                req_addr_i,
  input  logic [N_CLIENTS-1:0][DATA_W-1:0]                req_wdata_i,
  output logic [N_CLIENTS-1:0]                            req_ready_o,
  input  logic                                            prio_en_i,
  input  logic [$clog2(N_CLIENTS)-1:0]                    prio_client_i,
  output logic [N_BANKS-1:0]                              bank_read_o,
  output logic [N_BANKS-1:0]                              bank_write_o,
  output logic [N_BANKS-1:0][ADDR_W-$clog2(N_BANKS)-1:0]  bank_addr_o,
  output logic [N_BANKS-1:0][DATA_W-1:0]                  bank_wdata_o,
  input  logic [N_BANKS-1:0][DATA_W-1:0]                  bank_rdata_i,
  output logic [N_CLIENTS-1:0]                            rsp_valid_o,
  output logic [N_CLIENTS-1:0][DATA_W-1:0]                rsp_rdata_o
);

  localparam int CW   = $clog2(N_CLIENTS);
  localparam int BW   = $clog2(N_BANKS);
  localparam int BA_W = ADDR_W - BW;
  localparam int WW   = $clog2(STARVE_MAX + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX);

  logic [N_BANKS-1:0][N_CLIENTS-1:0] w_gnt;
  logic [N_BANKS-1:0][CW-1:0]        w_win;
  logic [N_BANKS-1:0]                w_any_gnt;
  logic [N_CLIENTS-1:0]              w_starving;
  logic                              w_prio_ok;

  logic [N_BANKS-1:0]                bank_read_q;
  logic [N_BANKS-1:0]                bank_write_q;
  logic [N_BANKS-1:0][BA_W-1:0]      bank_addr_q;
  logic [N_BANKS-1:0][DATA_W-1:0]    bank_wdata_q;
  logic [N_BANKS-1:0][CW-1:0]        bank_cid_q;
  logic [N_BANKS-1:0][CW-1:0]        ptr_q;
  logic [N_CLIENTS-1:0][WW-1:0]      wait_q;
  pipe_entry_t                       pipe_q [N_BANKS][RD_LAT];

  generate
    if (N_CLIENTS == (1 << CW)) begin : g_prio_full
      assign w_prio_ok = prio_en_i;
    end else begin : g_prio_part
      assign w_prio_ok = prio_en_i && (int'(prio_client_i) < N_CLIENTS);
    end
  endgenerate

  always_comb begin
    for (int c = 0; c < N_CLIENTS; c++) begin
      w_starving[c] = (wait_q[c] == WAIT_MAX);
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [N_CLIENTS-1:0] w_req;
    logic                 w_ovr_valid;
    logic [CW-1:0]        w_ovr_idx;

    // Override: lowest-index starving requester first, then the priority client.
    always_comb begin
      w_ovr_valid = 1'b0;
      w_ovr_idx   = '0;
      for (int c = 0; c < N_CLIENTS; c++) begin
        w_req[c] = req_valid_i[c] && (req_addr_i[c][BW-1:0] == BW'(b));
      end
      for (int c = N_CLIENTS - 1; c >= 0; c--) begin
        if (w_req[c] && w_starving[c]) begin
          w_ovr_valid = 1'b1;
          w_ovr_idx   = CW'(c);
        end
      end
      if (!w_ovr_valid && w_prio_ok && w_req[prio_client_i]) begin
        w_ovr_valid = 1'b1;
        w_ovr_idx   = prio_client_i;
      end
    end

    rr_arbiter #(.N(N_CLIENTS)) u_rr (
      .req_i       (w_req),
      .ptr_i       (ptr_q[b]),
      .ovr_valid_i (w_ovr_valid),
      .ovr_idx_i   (w_ovr_idx),
      .gnt_o       (w_gnt[b])
    );
  end

  always_comb begin
    w_win       = '0;
    w_any_gnt   = '0;
    req_ready_o = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      w_any_gnt[b] = |w_gnt[b];
      for (int c = 0; c < N_CLIENTS; c++) begin
        if (w_gnt[b][c]) begin
          w_win[b]       = w_win[b] | CW'(c);
          req_ready_o[c] = rst_n;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_read_q  <= '0;
      bank_write_q <= '0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      bank_cid_q   <= '0;
      ptr_q        <= '0;
      wait_q       <= '0;
      for (int b = 0; b < N_BANKS; b++) begin
        for (int k = 0; k < RD_LAT; k++) begin
          pipe_q[b][k] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        bank_read_q[b]  <= w_any_gnt[b] && !req_write_i[w_win[b]];
        bank_write_q[b] <= w_any_gnt[b] &&  req_write_i[w_win[b]];
        if (w_any_gnt[b]) begin
          bank_addr_q[b]  <= req_addr_i[w_win[b]][ADDR_W-1:BW];
          bank_wdata_q[b] <= req_wdata_i[w_win[b]];
          bank_cid_q[b]   <= w_win[b];
          ptr_q[b]        <= (w_win[b] == CW'(N_CLIENTS - 1)) ? '0 : w_win[b] + 1'b1;
        end
        // Pipeline starts at the strobe so its tail lines up with bank_rdata.
        pipe_q[b][0].valid <= bank_read_q[b];
        pipe_q[b][0].cid   <= CID_W'(bank_cid_q[b]);
        for (int k = 1; k < RD_LAT; k++) begin
          pipe_q[b][k] <= pipe_q[b][k-1];
        end
      end
      for (int c = 0; c < N_CLIENTS; c++) begin
        if (req_valid_i[c] && !req_ready_o[c]) begin
          wait_q[c] <= w_starving[c] ? wait_q[c] : wait_q[c] + 1'b1;
        end else begin
          wait_q[c] <= '0;
        end
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int c = 0; c < N_CLIENTS; c++) begin
        if (pipe_q[b][RD_LAT-1].valid && pipe_q[b][RD_LAT-1].cid == CID_W'(c)) begin
          rsp_valid_o[c] = 1'b1;
          rsp_rdata_o[c] = bank_rdata_i[b];
        end
      end
    end
  end

  assign bank_read_o  = bank_read_q;
  assign bank_write_o = bank_write_q;
  assign bank_addr_o  = bank_addr_q;
  assign bank_wdata_o = bank_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb_ctrl.sv
// ============================================================================
// tb_mem_arb_ctrl : directed bench with read-response scoreboard for mem_arb_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arb_ctrl;

  localparam int NC  = 16;
  localparam int NB  = 16;
  localparam int AW  = 19;
  localparam int DW  = 32;
  localparam int RL  = 2;
  localparam int SM  = 8;
  localparam int BAW = AW - 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NC-1:0]          req_valid = '0;
  logic [NC-1:0]          req_write = '0;
  logic [NC-1:0][AW-1:0]  req_addr = '0;
  logic [NC-1:0][DW-1:0]  req_wdata = '0;
  logic [NC-1:0]          req_ready;
  logic                   prio_en = 1'b0;
  logic [3:0]             prio_client = '0;
  logic [NB-1:0]          bank_read;
  logic [NB-1:0]          bank_write;
  logic [NB-1:0][BAW-1:0] bank_addr;
  logic [NB-1:0][DW-1:0]  bank_wdata;
  logic [NB-1:0][DW-1:0]  bank_rdata;
  logic [NC-1:0]          rsp_valid;
  logic [NC-1:0][DW-1:0]  rsp_rdata;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    int            due;
    int            client;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  mem_arb_ctrl #(
    .N_CLIENTS(NC), .N_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_MAX(SM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_ready_o   (req_ready),
    .prio_en_i     (prio_en),
    .prio_client_i (prio_client),
    .bank_read_o   (bank_read),
    .bank_write_o  (bank_write),
    .bank_addr_o   (bank_addr),
    .bank_wdata_o  (bank_wdata),
    .bank_rdata_i  (bank_rdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: read data is a tag of bank number and current cycle.
  function automatic logic [DW-1:0] mk(input int b, input int n);
    return {8'(b), 8'hA5, 16'(n)};
  endfunction

  always_comb begin
    for (int b = 0; b < NB; b++) bank_rdata[b] = mk(b, cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_reads(input logic [NC-1:0] g);
    int n;
    for (int c = 0; c < NC; c++) begin
      if (g[c] && !req_write[c]) begin
        n = cyc + RL + 1;
        sb.push_back('{due: n, client: c, data: mk(int'(req_addr[c][3:0]), n)});
      end
    end
  endtask

  task automatic chk_ready(input string tag, input logic [NC-1:0] exp);
    chk(tag, 64'(req_ready), 64'(exp));
    push_reads(exp);
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  task automatic clear();
    req_valid = '0;
    req_write = '0;
    prio_en   = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    rsp_t e;
    for (int c = 0; c < NC; c++) begin
      if (rsp_valid[c] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid[c]), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          chk("rsp_client", 64'(c), 64'(e.client));
          chk("rsp_data", 64'(rsp_rdata[c]), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] exp;
    bit            pw;

    // Reset with all clients requesting: nothing may be accepted.
    req_valid = '1;
    for (int c = 0; c < NC; c++) begin
      req_addr[c]  = 19'($urandom);
      req_write[c] = 1'($urandom);
    end
    nxt(); nxt();
    mid();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_read", 64'(bank_read), 64'(0));
    chk("rst_write", 64'(bank_write), 64'(0));
    chk("rst_baddr_nz", 64'(|bank_addr), 64'(0));
    chk("rst_wdata_nz", 64'(|bank_wdata), 64'(0));
    chk("rst_rsp", 64'(rsp_valid), 64'(0));
    nxt();
    rst_n = 1'b1;
    clear();
    idle(2);

    // Single read: client 5, addr 0x13 -> bank 3, bank_addr 1.
    req_valid    = 16'h0020;
    req_addr[5]  = 19'h00013;
    req_write[5] = 1'b0;
    mid(); chk_ready("single_hs", 16'h0020);
    nxt(); req_valid = '0;
    mid();
    chk("single_rd", 64'(bank_read), 64'h0008);
    chk("single_wr", 64'(bank_write), 64'(0));
    chk("single_baddr", 64'(bank_addr[3]), 64'h1);
    nxt(); mid();
    chk("hold_rd", 64'(bank_read), 64'(0));
    chk("hold_baddr", 64'(bank_addr[3]), 64'h1);
    nxt(); idle(4);

    // Round robin: clients 0,1,2 all read bank 3.
    req_valid = 16'h0007;
    for (int c = 0; c < 3; c++) req_addr[c] = 19'((c + 1) * 16 + 3);
    for (int k = 0; k < 9; k++) begin
      mid();
      exp = 16'(1 << (k % 3));
      chk_ready("rr_grant", exp);
      if (k > 0) begin
        chk("rr_strobe", 64'(bank_read), 64'h0008);
        chk("rr_baddr", 64'(bank_addr[3]), 64'((k - 1) % 3 + 1));
      end
      nxt();
    end
    clear();
    mid();
    chk("rr_strobe_last", 64'(bank_read), 64'h0008);
    chk("rr_baddr_last", 64'(bank_addr[3]), 64'h3);
    nxt(); idle(5);

    // Priority client 7 vs client 4 on bank 0; client 4 starves after 8 waits.
    req_valid    = 16'h0090;
    req_addr[4]  = 19'h00040;
    req_write[4] = 1'b1;
    req_wdata[4] = 32'hCAFE0004;
    req_addr[7]  = 19'h00070;
    req_write[7] = 1'b0;
    prio_en      = 1'b1;
    prio_client  = 4'd7;
    for (int k = 0; k < 18; k++) begin
      mid();
      exp = (k % 9 == 8) ? 16'h0010 : 16'h0080;
      chk_ready("starve_grant", exp);
      if (k > 0) begin
        pw = ((k - 1) % 9 == 8);
        chk("starve_wr", 64'(bank_write), pw ? 64'h1 : 64'h0);
        chk("starve_rd", 64'(bank_read), pw ? 64'h0 : 64'h1);
      end
      nxt();
    end
    clear();
    mid();
    chk("starve_wr_last", 64'(bank_write), 64'h1);
    chk("starve_wdata", 64'(bank_wdata[0]), 64'hCAFE0004);
    nxt(); idle(5);

    // All 16 clients to distinct banks, odd clients write.
    for (int c = 0; c < NC; c++) begin
      req_addr[c]  = 19'(((c + 32) << 4) | c);
      req_write[c] = c[0];
      req_wdata[c] = 32'hD0000000 | 32'(c);
    end
    req_valid = '1;
    mid(); chk_ready("par_ready", 16'hFFFF);
    nxt(); clear();
    mid();
    chk("par_rd", 64'(bank_read), 64'h5555);
    chk("par_wr", 64'(bank_write), 64'hAAAA);
    for (int c = 0; c < NC; c++) begin
      chk("par_baddr", 64'(bank_addr[c]), 64'(c + 32));
      if (c % 2 == 1) chk("par_wdata", 64'(bank_wdata[c]), 64'(32'hD0000000 | 32'(c)));
    end
    nxt(); idle(5);

    // Reset one cycle after a read handshake: response discarded, pointers cleared.
    req_valid    = 16'h0020;
    req_addr[5]  = 19'h00013;
    req_write[5] = 1'b0;
    mid(); chk("rst_pre_hs", 64'(req_ready), 64'h0020);
    nxt();
    rst_n        = 1'b0;
    req_valid    = 16'h0202;
    req_addr[1]  = 19'h00023;
    req_addr[9]  = 19'h00093;
    req_write[1] = 1'b0;
    req_write[9] = 1'b0;
    mid();
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_read", 64'(bank_read), 64'(0));
    chk("mid_rst_write", 64'(bank_write), 64'(0));
    chk("mid_rst_baddr_nz", 64'(|bank_addr), 64'(0));
    chk("mid_rst_wdata_nz", 64'(|bank_wdata), 64'(0));
    chk("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    nxt(); nxt();
    rst_n = 1'b1;
    mid(); chk_ready("ptr_rst_first", 16'h0002);
    nxt();
    mid(); chk_ready("ptr_rst_second", 16'h0200);
    nxt(); clear();
    idle(8);

    chk("sb_pending", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter N_CLIENTS, default 16, number of requesting clients.
REQ-002 SHALL have parameter N_BANKS, default 16, number of SRAM banks (power of 2).
REQ-003 SHALL have parameter ADDR_W, default 19, client word-address width.
REQ-004 SHALL have parameter DATA_W, default 32, data width.
REQ-005 SHALL have parameter RD_LAT, default 2, bank read latency in cycles (>=1).
REQ-006 SHALL have parameter STARVE_MAX, default 8, wait cycles before starvation override.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port req_valid, input, [N_CLIENTS], request pending per client.
REQ-010 SHALL have port req_write, input, [N_CLIENTS], 1=write, 0=read.
REQ-011 SHALL have port req_addr, input, [N_CLIENTS][ADDR_W], word address.
REQ-012 SHALL have port req_wdata, input, [N_CLIENTS][DATA_W], write data.
REQ-013 SHALL have port req_ready, output, [N_CLIENTS], request accepted this cycle.
REQ-014 SHALL have ports prio_en, input, 1, and prio_client, input, [$clog2(N_CLIENTS)], priority client select.
REQ-015 SHALL have ports bank_read, bank_write, output, [N_BANKS], registered bank strobes.
REQ-016 SHALL have ports bank_addr, output, [N_BANKS][ADDR_W-$clog2(N_BANKS)], and bank_wdata, output, [N_BANKS][DATA_W].
REQ-017 SHALL have port bank_rdata, input, [N_BANKS][DATA_W], valid RD_LAT cycles after bank_read.
REQ-018 SHALL have ports rsp_valid, output, [N_CLIENTS], and rsp_rdata, output, [N_CLIENTS][DATA_W], read return.

Function
REQ-019 Bank select SHALL be req_addr[$clog2(N_BANKS)-1:0]; bank_addr SHALL be the remaining upper bits.
REQ-020 Each bank SHALL grant at most one client per cycle; a client is granted by at most one bank (its addressed bank).
REQ-021 Per-bank winner order SHALL be: starving client (wait count == STARVE_MAX, lowest index first), then prio_client when prio_en=1, then round-robin from the bank's pointer.
REQ-022 req_ready SHALL be combinational from req_valid/req_addr and registered state; handshake occurs when req_valid & req_ready.
REQ-023 On a grant the bank's RR pointer SHALL update to (winner+1) mod N_CLIENTS; banks without a grant SHALL hold their pointer.
REQ-024 bank_read/bank_write, bank_addr, bank_wdata SHALL be registered, asserted exactly one cycle after the handshake, for one cycle.
REQ-025 Each bank SHALL carry a RD_LAT-deep shift pipeline of {valid, client id}; rsp_valid[c] and rsp_rdata[c]=bank_rdata[b] SHALL assert combinationally when bank b's pipeline output is valid for client c (RD_LAT+1 cycles after handshake).
REQ-026 Writes SHALL produce no response.
REQ-027 Per-client wait counter SHALL increment (saturating at STARVE_MAX) each cycle req_valid=1 and req_ready=0, and clear on handshake or req_valid=0.
REQ-028 Unstrobed bank outputs SHALL hold bank_addr/bank_wdata at previous values; strobes SHALL be 0.
REQ-029 prio_client >= N_CLIENTS SHALL be treated as prio_en=0.

Reset
REQ-030 While rst_n=0: strobes, read pipelines, wait counters SHALL be 0; RR pointers 0; bank_addr/bank_wdata 0; req_ready and rsp_valid 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight reads; no rsp_valid SHALL appear after release for pre-reset requests.

Structure
REQ-032 Shared package mem_ctrl_pkg SHALL hold default parameter constants and the bank-pipeline entry struct {valid, client id}.
REQ-033 A sub-module rr_arbiter (N-way request vector, pointer, override-index inputs, one-hot grant out) SHALL be instantiated once per bank.

Verification
REQ-034 Clients 0,1,2 read bank 3 continuously, prio_en=0 -> grants 0,1,2,0,... one per cycle; bank_read[3] one cycle after each.
REQ-035 Client 5 reads addr 0x00013 at t, RD_LAT=2 -> bank_read[3]=1, bank_addr[3]=0x0001 at t+1; rsp_valid[5] with bank_rdata[3] at t+3.
REQ-036 prio_en=1, prio_client=7, clients 4 and 7 both hit bank 0 every cycle -> 7 wins until client 4 waits 8 cycles, then 4 granted once.
REQ-037 16 clients each target a distinct bank, mixed read/write -> all req_ready=1 same cycle, 16 strobes next cycle, responses only for reads.
REQ-038 rst_n dropped one cycle after read handshake -> no rsp_valid after release; all outputs 0 during reset.
